// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, stall vectors and FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [5:0] StallNone  = 6'b000000;
    localparam logic [5:0] StallId    = 6'b000111;
    localparam logic [5:0] StallEx    = 6'b001111;
    localparam logic [5:0] StallDrain = 6'b000011;

    localparam logic [31:0] WdogVectorDefault = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        CtrlRun   = 2'd0,
        CtrlFlush = 2'd1,
        CtrlDrain = 2'd2
    } ctrl_state_e;

    // Execute holds take precedence since they freeze one more stage than decode holds.
    function automatic logic [5:0] stall_sel(input logic id_req, input logic ex_req);
        if (ex_req)      return StallEx;
        else if (id_req) return StallId;
        else             return StallNone;
    endfunction

endpackage

// File: rtl/pipe_wdog.sv
// rtl/pipe_wdog.sv - watchdog counting consecutive execute-stage hold cycles
module pipe_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req,
    output logic fire
);

    localparam logic [15:0] LastCount = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    assign fire = en && req && (cnt_q == LastCount);

    // Disabling doubles as clear, so the count sits at zero outside RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || !req || fire) cnt_d = '0;
        else                     cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) cnt_q <= '0;
        else                  cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer; stall-cycle counter under PIPE_CTRL_PERF_CNT_EN
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT   = 64,
    parameter logic [31:0] WDOG_VECTOR  = WdogVectorDefault,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        excp_valid_i,
    input  logic [31:0] excp_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        wdog_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [3:0] DrainLoad = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

    ctrl_state_e state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        wdog_q, wdog_d;
    logic        wdog_en, wdog_fire;

    // A same-cycle exception suppresses the watchdog and clears its count.
    assign wdog_en = (state_q == CtrlRun) && !excp_valid_i;

    pipe_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clk  (clk),
        .rst  (rst),
        .en   (wdog_en),
        .req  (stallreq_from_ex),
        .fire (wdog_fire)
    );

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        new_pc_d = new_pc_q;
        wdog_d   = 1'b0;
        stall_o  = StallNone;
        flush_o  = 1'b0;
        case (state_q)
            CtrlRun: begin
                stall_o = stall_sel(stallreq_from_id, stallreq_from_ex);
                if (excp_valid_i) begin
                    state_d  = CtrlFlush;
                    new_pc_d = excp_pc_i;
                end else if (wdog_fire) begin
                    state_d  = CtrlFlush;
                    new_pc_d = WDOG_VECTOR;
                    wdog_d   = 1'b1;
                end
            end
            CtrlFlush: begin
                flush_o = 1'b1;
                if (DRAIN_CYCLES > 0) begin
                    state_d = CtrlDrain;
                    drain_d = DrainLoad;
                end else begin
                    state_d = CtrlRun;
                end
            end
            CtrlDrain: begin
                stall_o = StallDrain;
                if (excp_valid_i) begin
                    state_d  = CtrlFlush;
                    new_pc_d = excp_pc_i;
                end else if (drain_q == 4'd0) begin
                    state_d = CtrlRun;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = CtrlRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= CtrlRun;
            drain_q  <= '0;
            new_pc_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            new_pc_q <= new_pc_d;
            wdog_q   <= wdog_d;
        end
    end

    assign new_pc_o = new_pc_q;
    assign wdog_o   = wdog_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            stall_cycles_q <= '0;
        else if ((stall_o != StallNone) && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign stall_cycles_o = stall_cycles_q;
`else
    assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage OpenMIPS32 pipeline (pc, if, id, ex, mem, wb).
- Merges stall requests from the decode stage (load-use hazards that operand forwarding cannot cover) and the execute stage (multi-cycle ops) into one per-stage stall vector.
- Sequences an exception flush and redirects the PC.
- Guards against a hung execute unit with a watchdog.

Parameters:
- WDOG_LIMIT, 64: number of consecutive cycles of stallreq_from_ex before the watchdog fires; legal range 2..65535.
- WDOG_VECTOR, 32'hBFC0_0380: PC loaded when the watchdog fires.
- DRAIN_CYCLES, 2: number of bubble cycles after a flush during which pc/if stay stalled; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high (rst == `RstEnable).
- stallreq_from_id  in  1  decode requests a one-cycle hold.
- stallreq_from_ex  in  1  execute requests a hold (multi-cycle op busy).
- excp_valid_i  in  1  exception committed in mem; single-cycle pulse.
- excp_pc_i  in  32  handler address, valid with excp_valid_i.
- stall_o  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush_o  out  1  clears all pipeline registers this cycle.
- new_pc_o  out  32  redirect target, valid while flush_o=1.
- wdog_o  out  1  one-cycle pulse when the watchdog fires.
- stall_cycles_o  out  32  count of stalled cycles (see Optional Feature).

Behaviour:
- Reset: state=RUN; stall_o=6'b000000; flush_o=0; new_pc_o=32'h0; wdog_o=0; watchdog counter=0; drain counter=0; stall_cycles_o=0.
- FSM states: RUN, FLUSH, DRAIN.
- RUN:
  - stall_o is combinational from the current-cycle requests, zero latency.
  - stallreq_from_ex=1 gives 6'b001111. Else stallreq_from_id=1 gives 6'b000111. Else 6'b000000.
  - If excp_valid_i=1: latch excp_pc_i and go to FLUSH next cycle. stall_o that cycle is still driven from the requests.
- FLUSH (exactly one cycle):
  - flush_o=1, new_pc_o=latched target, stall_o=6'b000000. Requests are ignored.
  - Next state: DRAIN if DRAIN_CYCLES>0, else RUN.
- DRAIN:
  - stall_o=6'b000011; flush_o=0.
  - Drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; return to RUN when it is 0.
  - Requests are ignored. An excp_valid_i arriving here re-enters FLUSH next cycle with the new target (latest exception wins).
- new_pc_o holds its last value outside FLUSH. It is meaningful only when flush_o=1.
- Watchdog counter:
  - 16-bit; in RUN, increments while stallreq_from_ex=1 and clears when it is 0.
  - When it reaches WDOG_LIMIT-1 with stallreq_from_ex still 1: next cycle wdog_o=1, latched target=WDOG_VECTOR, state=FLUSH, counter cleared.
  - The counter holds at 0 in FLUSH/DRAIN.
- Simultaneous excp_valid_i and watchdog expiry in the same cycle: the exception has priority; its target is used, wdog_o stays 0 and the counter is cleared.
- Reset asserted mid-FLUSH/DRAIN: next cycle is RUN with all outputs at reset values; no flush completes.
- Stall monotonicity: a stalled stage always implies every earlier stage is stalled. Verification asserts this every cycle.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined: stall_cycles_o increments by 1 on every cycle where stall_o!=0. It saturates at 32'hFFFF_FFFF (no wrap) and clears only on reset.
- Undefined: no counter register is built and stall_cycles_o is tied to 32'h0.

Decomposition:
- Shared defines file (alongside RstEnable/WriteEnable etc.):
  - Stall vector constants: StallNone 6'b000000, StallId 6'b000111, StallEx 6'b001111, StallDrain 6'b000011.
  - State encodings: CtrlRun, CtrlFlush, CtrlDrain.
  - Default WDOG_VECTOR.
- One sub-module: pipe_wdog. It holds the watchdog counter and compare, with ports clk, rst, en, req, fire. The FSM and the stall mux stay in pipe_ctrl.

Test Plan:
- Decode stall only: stallreq_from_id=1 for one cycle in RUN -> stall_o=6'b000111 that same cycle, 6'b000000 the next; flush_o stays 0.
- Both requests together: id=1 and ex=1 -> stall_o=6'b001111. Drop ex and keep id -> 6'b000111.
- Exception: excp_valid_i pulse with excp_pc_i=32'h0000_0040 -> next cycle flush_o=1, new_pc_o=32'h40, stall_o=0. Then 2 cycles of stall_o=6'b000011 (DRAIN_CYCLES=2), then RUN.
- Watchdog: WDOG_LIMIT=4, ex held high -> stall_o=6'b001111 for 4 cycles, then wdog_o=1 and flush_o=1 with new_pc_o=32'hBFC0_0380. A variant with excp_valid_i on the expiry cycle -> exception target used, wdog_o=0.
- Reset mid-drain: rst=1 on the first DRAIN cycle -> next cycle stall_o=0, flush_o=0, state RUN. ex then stalls 3 cycles -> stall_o=6'b001111, no watchdog.
- PIPE_CTRL_PERF_CNT_EN defined: 5 stalled cycles -> stall_cycles_o=5. Counter preloaded to 32'hFFFF_FFFF stays saturated. With the macro undefined -> stall_cycles_o=0 throughout.
